// File: rtl/im_fetch_pkg.sv
// Shared types and helpers for the instruction-memory fetch sequencer.
// Contents: fetch state enum, queue entry payload, word size, PC legality check.
package im_fetch_pkg;

    localparam int unsigned WORD_BYTES = 4;

    typedef enum logic [0:0] {
        FETCH = 1'b0,
        FAULT = 1'b1
    } fetch_state_e;

    typedef struct packed {
        logic [31:0] instr;
        logic [31:0] pc;
    } fetch_entry_t;

    // Word-aligned and the whole word lies inside the memory; 33-bit sum so pc+3 cannot wrap.
    function automatic logic is_legal_pc(input logic [31:0] pc, input int unsigned mem_size);
        logic [32:0] last_byte;
        last_byte = {1'b0, pc} + 33'(WORD_BYTES - 1);
        return (pc[1:0] == 2'b00) && (last_byte < 33'(mem_size));
    endfunction

endpackage

// File: rtl/im_fetch_queue.sv
// Small synchronous FIFO of fetched {instr, pc} entries with flush.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   flush               empty the queue at the edge (wins over push)
//   push, push_data     write one entry
//   pop                 retire the head entry
//   head, head_valid    current head entry and registered non-empty flag
//   full_c              queue holds DEPTH entries (combinational from the count)
module im_fetch_queue
    import im_fetch_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         head_valid,
    output logic         full_c
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    fetch_entry_t     mem_q [DEPTH];
    fetch_entry_t     mem_d [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             valid_q, valid_d;

    // Next-state: pointers wrap naturally because DEPTH is a power of two.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = push_data;
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            if (push && !pop) begin
                count_d = count_q + CNT_W'(1);
            end else if (pop && !push) begin
                count_d = count_q - CNT_W'(1);
            end
        end
        valid_d = (count_d != '0);
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            valid_q  <= 1'b0;
        end else begin
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            valid_q  <= valid_d;
        end
    end

    assign head       = mem_q[rd_ptr_q];
    assign head_valid = valid_q;
    assign full_c     = (count_q == CNT_W'(DEPTH));

    // The controller only pushes into a full queue when it also pops, and only pops a valid head.
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !pop && !flush && full_c))
        else $error("im_fetch_queue: push into full queue");

    a_no_underflow : assert property (@(posedge clk) disable iff (!rst_n)
        !(pop && !valid_q))
        else $error("im_fetch_queue: pop from empty queue");

endmodule

// File: rtl/im_fetch_ctrl.sv
// Fetch sequencer for a combinationally-read, big-endian instruction memory.
// Owns the fetch PC, captures returned words into a queue and presents them to
// decode over valid/ready. Handles redirects (flush) and illegal-PC faults.
// Optional macro IM_FETCH_PERF_EN adds saturating perf counters.
// Ports:
//   clk, rst_n                     clock, async active-low reset
//   instr_addr / instr_rdata       IM address (= fetch PC) and returned word
//   out_valid/out_ready            decode handshake; out_instr/out_pc are the head
//   redir_valid/redir_pc           one-cycle redirect request and target
//   fault/fault_pc                 fetch stopped on an illegal PC, and that PC
//   perf_fetch/stall/flush         (IM_FETCH_PERF_EN only) pushes, stall cycles, redirects
module im_fetch_ctrl
    import im_fetch_pkg::*;
#(
    parameter int unsigned MEM_SIZE = 128,
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned Q_DEPTH  = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] instr_addr,
    input  logic [31:0] instr_rdata,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_instr,
    output logic [31:0] out_pc,
    input  logic        redir_valid,
    input  logic [31:0] redir_pc,
    output logic        fault,
    output logic [31:0] fault_pc
`ifdef IM_FETCH_PERF_EN
    ,
    output logic [31:0] perf_fetch,
    output logic [31:0] perf_stall,
    output logic [31:0] perf_flush
`endif
);

    fetch_state_e state_q, state_d;
    logic [31:0]  fetch_pc_q, fetch_pc_d;
    logic         fault_q, fault_d;
    logic [31:0]  fault_pc_q, fault_pc_d;

    logic         push_c;
    logic         pop_c;
    logic         pc_legal_c;
    logic         q_full_c;
    logic         q_valid;
    fetch_entry_t q_head;
    fetch_entry_t push_entry_c;

    assign pop_c        = q_valid && out_ready;
    assign pc_legal_c   = is_legal_pc(fetch_pc_q, MEM_SIZE);
    assign push_entry_c = '{instr: instr_rdata, pc: fetch_pc_q};

    // Next-state / control: redirect overrides everything and discards any push.
    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        fault_d    = fault_q;
        fault_pc_d = fault_pc_q;
        push_c     = 1'b0;
        if (redir_valid) begin
            state_d    = FETCH;
            fetch_pc_d = redir_pc;
            fault_d    = 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (pc_legal_c) begin
                        if (!q_full_c || pop_c) begin
                            push_c     = 1'b1;
                            fetch_pc_d = fetch_pc_q + 32'(WORD_BYTES);
                        end
                    end else begin
                        state_d    = FAULT;
                        fault_d    = 1'b1;
                        fault_pc_d = fetch_pc_q;
                    end
                end
                FAULT: begin
                    state_d = FAULT;
                end
                default: begin
                    state_d = FETCH;
                end
            endcase
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= FETCH;
            fetch_pc_q <= RESET_PC;
            fault_q    <= 1'b0;
            fault_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
            fault_q    <= fault_d;
            fault_pc_q <= fault_pc_d;
        end
    end

    im_fetch_queue #(
        .DEPTH (Q_DEPTH)
    ) u_queue (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redir_valid),
        .push       (push_c),
        .push_data  (push_entry_c),
        .pop        (pop_c),
        .head       (q_head),
        .head_valid (q_valid),
        .full_c     (q_full_c)
    );

    assign instr_addr = fetch_pc_q;
    assign out_valid  = q_valid;
    assign out_instr  = q_head.instr;
    assign out_pc     = q_head.pc;
    assign fault      = fault_q;
    assign fault_pc   = fault_pc_q;

`ifdef IM_FETCH_PERF_EN
    logic [31:0] perf_fetch_q, perf_fetch_d;
    logic [31:0] perf_stall_q, perf_stall_d;
    logic [31:0] perf_flush_q, perf_flush_d;

    // Saturating event counters.
    always_comb begin
        perf_fetch_d = perf_fetch_q;
        perf_stall_d = perf_stall_q;
        perf_flush_d = perf_flush_q;
        if (push_c && (perf_fetch_q != '1)) begin
            perf_fetch_d = perf_fetch_q + 32'd1;
        end
        if (q_valid && !out_ready && (perf_stall_q != '1)) begin
            perf_stall_d = perf_stall_q + 32'd1;
        end
        if (redir_valid && (perf_flush_q != '1)) begin
            perf_flush_d = perf_flush_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            perf_fetch_q <= '0;
            perf_stall_q <= '0;
            perf_flush_q <= '0;
        end else begin
            perf_fetch_q <= perf_fetch_d;
            perf_stall_q <= perf_stall_d;
            perf_flush_q <= perf_flush_d;
        end
    end

    assign perf_fetch = perf_fetch_q;
    assign perf_stall = perf_stall_q;
    assign perf_flush = perf_flush_q;
`endif

endmodule

// File: tb/tb_im_fetch_ctrl.sv
// Bench for im_fetch_ctrl: directed scenarios then randomized traffic, all
// checked against a queue-based reference model of the fetch rules.
module tb_im_fetch_ctrl;

    localparam int unsigned MEM_SIZE = 128;
    localparam int unsigned QD       = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] instr_addr;
    logic [31:0] instr_rdata;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_instr;
    logic [31:0] out_pc;
    logic        redir_valid;
    logic [31:0] redir_pc;
    logic        fault;
    logic [31:0] fault_pc;
`ifdef IM_FETCH_PERF_EN
    logic [31:0] perf_fetch;
    logic [31:0] perf_stall;
    logic [31:0] perf_flush;
`endif

    im_fetch_ctrl #(
        .MEM_SIZE (MEM_SIZE),
        .RESET_PC (32'h0000_0000),
        .Q_DEPTH  (QD)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .instr_addr  (instr_addr),
        .instr_rdata (instr_rdata),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_instr   (out_instr),
        .out_pc      (out_pc),
        .redir_valid (redir_valid),
        .redir_pc    (redir_pc),
        .fault       (fault),
        .fault_pc    (fault_pc)
`ifdef IM_FETCH_PERF_EN
        ,
        .perf_fetch  (perf_fetch),
        .perf_stall  (perf_stall),
        .perf_flush  (perf_flush)
`endif
    );

    always #5 clk = ~clk;

    // Byte-addressed big-endian instruction memory, read combinationally.
    logic [7:0] im [0:127];

    function automatic logic [31:0] word_at(input logic [31:0] a);
        if (a < 32'd125) begin
            return {im[a[6:0]], im[a[6:0] + 7'd1], im[a[6:0] + 7'd2], im[a[6:0] + 7'd3]};
        end
        return 32'hDEAD_BEEF;
    endfunction

    always_comb begin
        instr_rdata = 32'hDEAD_BEEF;
        if (instr_addr < 32'd125) begin
            instr_rdata = {im[instr_addr[6:0]], im[instr_addr[6:0] + 7'd1],
                           im[instr_addr[6:0] + 7'd2], im[instr_addr[6:0] + 7'd3]};
        end
    end

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Reference model: what decode should see, expressed as a list of pending words.
    typedef struct {
        logic [31:0] instr;
        logic [31:0] pc;
    } ent_t;

    ent_t        mq [$];
    logic [31:0] m_pc;
    logic        m_fault;
    logic [31:0] m_fault_pc;

    function automatic logic m_legal(input logic [31:0] pc);
        longint unsigned last;
        last = longint'(pc) + 64'd3;
        return ((pc % 32'd4) == 32'd0) && (last < 64'(MEM_SIZE));
    endfunction

    task automatic model_reset();
        mq.delete();
        m_pc       = 32'h0;
        m_fault    = 1'b0;
        m_fault_pc = 32'h0;
    endtask

    task automatic model_step();
        logic pop;
        logic room;
        ent_t e;
        pop  = (mq.size() != 0) && out_ready;
        room = (mq.size() < int'(QD)) || pop;
        if (redir_valid) begin
            mq.delete();
            m_pc    = redir_pc;
            m_fault = 1'b0;
        end else begin
            if (pop) void'(mq.pop_front());
            if (!m_fault) begin
                if (!m_legal(m_pc)) begin
                    m_fault    = 1'b1;
                    m_fault_pc = m_pc;
                end else if (room) begin
                    e.instr = word_at(m_pc);
                    e.pc    = m_pc;
                    mq.push_back(e);
                    m_pc = m_pc + 32'd4;
                end
            end
        end
    endtask

    task automatic compare_all();
        chk("out_valid", 32'(out_valid), 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("out_instr", out_instr, mq[0].instr);
            chk("out_pc", out_pc, mq[0].pc);
        end
        chk("fault", 32'(fault), 32'(m_fault));
        chk("fault_pc", fault_pc, m_fault_pc);
        chk("instr_addr", instr_addr, m_pc);
    endtask

    // One clock: check at the falling edge, drive inputs, advance the model.
    task automatic cycle(input logic rdy, input logic rv, input logic [31:0] rpc);
        compare_all();
        out_ready   = rdy;
        redir_valid = rv;
        redir_pc    = rpc;
        model_step();
        @(negedge clk);
    endtask

    function automatic logic [31:0] pick_target();
        logic [31:0] t;
        case ($urandom_range(0, 5))
            0, 1, 2: t = 32'($urandom_range(0, 31)) << 2;
            3:       t = 32'h74 + (32'($urandom_range(0, 3)) << 2);
            4:       t = (32'($urandom_range(0, 31)) << 2) | 32'($urandom_range(1, 3));
            default: t = $urandom() & 32'hFFFF_FFFC;
        endcase
        return t;
    endfunction

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_out_valid"}, 32'(out_valid), 32'h0);
        chk({tag, "_out_instr"}, out_instr, 32'h0);
        chk({tag, "_out_pc"}, out_pc, 32'h0);
        chk({tag, "_fault"}, 32'(fault), 32'h0);
        chk({tag, "_fault_pc"}, fault_pc, 32'h0);
        chk({tag, "_instr_addr"}, instr_addr, 32'h0);
`ifdef IM_FETCH_PERF_EN
        chk({tag, "_perf_fetch"}, perf_fetch, 32'h0);
        chk({tag, "_perf_stall"}, perf_stall, 32'h0);
        chk({tag, "_perf_flush"}, perf_flush, 32'h0);
`endif
    endtask

    initial begin
        logic [31:0] w;
        rst_n       = 1'b0;
        out_ready   = 1'b0;
        redir_valid = 1'b0;
        redir_pc    = 32'h0;
        for (int a = 0; a < 128; a++) im[a] = 8'($urandom());
        for (int k = 0; k < 8; k++) begin
            w = 32'h1111_1111 * 32'(k + 1);
            for (int b = 0; b < 4; b++) im[4 * k + b] = w[31 - 8 * b -: 8];
        end
        model_reset();

        repeat (2) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;

        // First word one cycle after release, then streaming 0x00..0x1C.
        cycle(1'b1, 1'b0, 32'h0);
        chk("first_valid", 32'(out_valid), 32'h1);
        chk("first_pc", out_pc, 32'h0);
        chk("first_instr", out_instr, 32'h1111_1111);
        repeat (8) cycle(1'b1, 1'b0, 32'h0);

        // Back-pressure: queue fills, fetch stalls at 0x08, head holds.
        cycle(1'b1, 1'b1, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        repeat (5) cycle(1'b0, 1'b0, 32'h0);
        chk("stall_addr", instr_addr, 32'h8);
        chk("stall_head_pc", out_pc, 32'h0);
        chk("stall_head_instr", out_instr, 32'h1111_1111);
        repeat (6) cycle(1'b1, 1'b0, 32'h0);

        // Redirect coinciding with a pop of 0x04.
        cycle(1'b1, 1'b1, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        cycle(1'b0, 1'b0, 32'h0);
        chk("redir_head_pc", out_pc, 32'h4);
        cycle(1'b1, 1'b1, 32'h40);
        chk("redir_bubble", 32'(out_valid), 32'h0);
        cycle(1'b1, 1'b0, 32'h0);
        chk("redir_target_pc", out_pc, 32'h40);
        chk("redir_target_valid", 32'(out_valid), 32'h1);

        // Running off the end of memory.
        cycle(1'b1, 1'b1, 32'h70);
        repeat (5) cycle(1'b1, 1'b0, 32'h0);
        chk("end_fault", 32'(fault), 32'h1);
        chk("end_fault_pc", fault_pc, 32'h80);
        chk("end_addr", instr_addr, 32'h80);
        repeat (2) cycle(1'b1, 1'b0, 32'h0);
        chk("end_drained", 32'(out_valid), 32'h0);
        cycle(1'b1, 1'b1, 32'h0);
        chk("recover_fault", 32'(fault), 32'h0);
        chk("recover_fault_pc", fault_pc, 32'h80);
        repeat (3) cycle(1'b1, 1'b0, 32'h0);

        // Misaligned redirect.
        cycle(1'b1, 1'b1, 32'h6);
        cycle(1'b1, 1'b0, 32'h0);
        chk("misalign_fault", 32'(fault), 32'h1);
        chk("misalign_fault_pc", fault_pc, 32'h6);
        chk("misalign_valid", 32'(out_valid), 32'h0);
        repeat (2) cycle(1'b1, 1'b0, 32'h0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            cycle(1'($urandom_range(0, 9) < 7), 1'($urandom_range(0, 99) < 6), pick_target());
        end

        // Asynchronous reset with a full queue.
        cycle(1'b1, 1'b1, 32'h0);
        repeat (3) cycle(1'b0, 1'b0, 32'h0);
        chk("prereset_full_valid", 32'(out_valid), 32'h1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check_reset_outputs("async_reset");
        @(negedge clk);
        model_reset();
        rst_n = 1'b1;
        repeat (10) cycle(1'b1, 1'b0, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/im_fetch_ctrl.md
Name: im_fetch_ctrl

Overview:
- Sequencer for the byte-addressed, big-endian, combinationally-read instruction memory (128 bytes, 4 bytes per word).
- Owns the fetch PC and drives the IM address. Captures each returned word into a small queue and hands it to decode over a valid/ready handshake.
- Handles branch redirects, flushes, and out-of-range/misaligned fetch faults.

Parameters:
- MEM_SIZE, 128: IM size in bytes; the legal fetch window is pc+3 <= MEM_SIZE-1.
- RESET_PC, 32'h0000_0000: fetch PC loaded on reset.
- Q_DEPTH, 2: fetch queue entries; must be a power of two and >= 2.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- instr_addr  output  32  address to IM; equals fetch_pc.
- instr_rdata  input  32  word from IM, combinational from instr_addr.
- out_valid  output  1  queue head holds a valid instruction.
- out_ready  input  1  decode accepts the head this cycle.
- out_instr  output  32  head instruction word.
- out_pc  output  32  byte address of the head instruction.
- redir_valid  input  1  redirect request (branch/jump/exception), one-cycle pulse.
- redir_pc  input  32  redirect target.
- fault  output  1  fetch stopped on an illegal PC.
- fault_pc  output  32  the illegal PC that caused the fault.

Behaviour:
- Reset (async assert, sync release): fetch_pc=RESET_PC, queue empty, state=FETCH. Output reset values: out_valid=0, out_instr=0, out_pc=0, fault=0, fault_pc=0.
- instr_addr = fetch_pc at all times, including in FAULT.
- State FETCH:
  - Legal PC: fetch_pc[1:0]==0 and fetch_pc+3 < MEM_SIZE, computed 33-bit so there is no wrap.
  - If the PC is legal and the queue is not full, or a pop happens this cycle, push {instr_rdata, fetch_pc} and advance fetch_pc by 4.
  - If the PC is illegal: do not push. Go to FAULT, latch fault_pc=fetch_pc, set fault=1 from the next cycle.
- State FAULT:
  - No pushes. The queue drains normally through the handshake.
  - fault stays high until a redirect or reset.
- Handshake: a pop happens when out_valid && out_ready. The head is stable while out_valid && !out_ready.
- Pop and push in the same cycle on a full queue are allowed; occupancy is unchanged.
- Latency:
  - The first word is visible on out_valid one cycle after reset release.
  - Sustained throughput is 1 instruction/cycle while out_ready=1.
- Redirect (highest priority):
  - In the redir_valid cycle, a simultaneous pop still completes, because decode consumed it.
  - At the clock edge: queue flushed, any same-cycle push discarded, fetch_pc=redir_pc, state=FETCH, fault cleared to 0, fault_pc holds its last value.
  - out_valid=0 in the cycle after a redirect. The new target word is valid the following cycle if legal.
- Redirect to an illegal PC: flush, then FAULT one cycle later with fault_pc=redir_pc.
- Queue pointers wrap modulo Q_DEPTH. Occupancy counter is log2(Q_DEPTH)+1 bits. No overflow or underflow is possible by construction; an assertion checks this.

Optional Feature:
- Macro: IM_FETCH_PERF_EN.
- Defined: adds outputs perf_fetch[31:0] (pushes), perf_stall[31:0] (cycles with out_valid && !out_ready) and perf_flush[31:0] (redirects).
  - All three counters reset to 0 and saturate at 32'hFFFF_FFFF.
- Undefined: the ports and logic are absent, and behaviour is otherwise identical.

Decomposition:
- Package im_fetch_pkg holds:
  - the state typedef {FETCH, FAULT};
  - the queue entry struct {instr[31:0], pc[31:0]};
  - the WORD_BYTES=4 constant;
  - a function is_legal_pc(pc, mem_size).
- One sub-module: im_fetch_queue, a synchronous FIFO of entries with flush, push, pop, full and empty. The controller instantiates it once.

Test Plan:
- Reset release, IM preloaded with words 0x11111111..0x88888888 at 0x00..0x1C, out_ready=1 -> out_valid from cycle 1, out_pc 0x00,0x04,...,0x1C consecutive, one per cycle.
- out_ready=0 for 5 cycles after the first word -> queue fills to 2 entries, instr_addr stalls at 0x08, head stays 0x11111111/pc 0x00. On release, words arrive in order with none lost.
- redir_valid with redir_pc=0x40 in the same cycle as a pop of pc 0x04 -> 0x04 counted as delivered, queued 0x08 dropped, out_valid=0 for one cycle, next out_pc=0x40.
- Sequential fetch reaches pc=0x7C (legal) then 0x80 -> 0x7C delivered, fault=1 and fault_pc=0x80, no further pushes. Then redirect to 0x00 -> fault=0 and fetch resumes.
- Redirect to 0x06 (misaligned) -> flush, fault=1 and fault_pc=0x06, out_valid remains 0.
- rst_n pulsed low mid-stream with a full queue -> out_valid drops to 0 immediately and asynchronously. After release, fetch restarts at RESET_PC; perf counters (if enabled) read 0.
